// File: rtl/button_conditioner_if.sv
// Button conditioner signal bundle: raw active-low pins in, clean
// debounced level and event pulses out.
interface button_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_n;        // raw pins, 0 = pressed
    logic [NUM_BTN-1:0] btn_level;    // debounced state, 1 = pressed
    logic [NUM_BTN-1:0] btn_press;    // one-cycle pulse on accepted press
    logic [NUM_BTN-1:0] btn_release;  // one-cycle pulse on accepted release
    logic [NUM_BTN-1:0] btn_long;     // one-cycle pulse after a long hold
    logic [NUM_BTN-1:0] btn_toggle;   // flips on every accepted press

    // Board / consumer side: drives the pins, observes the events
    modport master (
        output btn_n,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long,
        input  btn_toggle
    );

    // Conditioner side
    modport slave (
        input  btn_n,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long,
        output btn_toggle
    );
endinterface

// File: rtl/button_conditioner.sv
// Push-button front end: two-flop synchroniser per pin, then an
// independent debounce/hold state machine per channel producing a clean
// level, press/release/long-press pulses and a press-toggled flag.
module button_conditioner #(
    parameter int NUM_BTN     = 3,
    parameter int DEB_CYCLES  = 1000000,
    parameter int LONG_CYCLES = 100000000,
    parameter int CNT_W       = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    button_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_RELEASE
    } state_t;

    logic [NUM_BTN-1:0] s1_reg;
    logic [NUM_BTN-1:0] s2_reg;

    // Two-flop synchroniser; resets to the released (high) pin level
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_reg <= '1;
            s2_reg <= '1;
        end else begin
            s1_reg <= bus.btn_n;
            s2_reg <= s1_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_ch
            state_t           state_reg,     state_next;
            logic [CNT_W-1:0] deb_cnt_reg,   deb_cnt_next;
            logic [CNT_W-1:0] hold_cnt_reg,  hold_cnt_next;
            logic             long_done_reg, long_done_next;
            logic             level_reg,     level_next;
            logic             toggle_reg,    toggle_next;
            logic             press_reg,     press_next;
            logic             release_reg,   release_next;
            logic             long_reg,      long_next;
            logic             p;

            // Internal polarity: 1 while the synchronised button is held
            assign p = ~s2_reg[gi];

            // Channel state and registered outputs
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    state_reg     <= IDLE;
                    deb_cnt_reg   <= '0;
                    hold_cnt_reg  <= '0;
                    long_done_reg <= 1'b0;
                    level_reg     <= 1'b0;
                    toggle_reg    <= 1'b0;
                    press_reg     <= 1'b0;
                    release_reg   <= 1'b0;
                    long_reg      <= 1'b0;
                end else begin
                    state_reg     <= state_next;
                    deb_cnt_reg   <= deb_cnt_next;
                    hold_cnt_reg  <= hold_cnt_next;
                    long_done_reg <= long_done_next;
                    level_reg     <= level_next;
                    toggle_reg    <= toggle_next;
                    press_reg     <= press_next;
                    release_reg   <= release_next;
                    long_reg      <= long_next;
                end
            end

            // Debounce / hold decisions; pulses default low every cycle
            always_comb begin
                state_next     = state_reg;
                deb_cnt_next   = deb_cnt_reg;
                hold_cnt_next  = hold_cnt_reg;
                long_done_next = long_done_reg;
                level_next     = level_reg;
                toggle_next    = toggle_reg;
                press_next     = 1'b0;
                release_next   = 1'b0;
                long_next      = 1'b0;
                case (state_reg)
                    IDLE: begin
                        if (p) begin
                            state_next   = DEB_PRESS;
                            deb_cnt_next = '0;
                        end
                    end
                    DEB_PRESS: begin
                        if (!p) begin
                            state_next = IDLE;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next     = PRESSED;
                            press_next     = 1'b1;
                            level_next     = 1'b1;
                            toggle_next    = ~toggle_reg;
                            hold_cnt_next  = '0;
                            long_done_next = 1'b0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    PRESSED: begin
                        if (!p) begin
                            state_next   = DEB_RELEASE;
                            deb_cnt_next = '0;
                        end else if (hold_cnt_reg == LONG_LAST && !long_done_reg) begin
                            long_next      = 1'b1;
                            long_done_next = 1'b1;
                        end else if (hold_cnt_reg < LONG_LAST) begin
                            hold_cnt_next = hold_cnt_reg + 1'b1;
                        end
                    end
                    DEB_RELEASE: begin
                        // hold_cnt is frozen here so a short glitch does not
                        // restart the long-press timer
                        if (p) begin
                            state_next = PRESSED;
                        end else if (deb_cnt_reg == DEB_LAST) begin
                            state_next   = IDLE;
                            release_next = 1'b1;
                            level_next   = 1'b0;
                        end else begin
                            deb_cnt_next = deb_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_next = IDLE;
                    end
                endcase
            end

            assign bus.btn_level[gi]   = level_reg;
            assign bus.btn_press[gi]   = press_reg;
            assign bus.btn_release[gi] = release_reg;
            assign bus.btn_long[gi]    = long_reg;
            assign bus.btn_toggle[gi]  = toggle_reg;
        end
    endgenerate

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: directed scenarios followed
// by random bouncing, every cycle compared against a run-length model.
module tb_button_conditioner;

    localparam int NB   = 3;
    localparam int DEB  = 4;
    localparam int LONG = 10;

    logic clk = 1'b0;
    logic rst_n;

    int checks   = 0;
    int failures = 0;

    button_conditioner_if #(.NUM_BTN(NB)) bif ();

    button_conditioner #(
        .NUM_BTN    (NB),
        .DEB_CYCLES (DEB),
        .LONG_CYCLES(LONG),
        .CNT_W      (32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bif.slave)
    );

    always #5 clk = ~clk;

    // Reference model: level accepted after DEB+1 consecutive disagreeing
    // samples of the twice-delayed pin; long press on the LONG-th steady
    // held sample after the press.
    logic [NB-1:0] m_s1, m_s2;
    int            m_run  [NB];
    int            m_held [NB];
    logic [NB-1:0] e_level, e_press, e_release, e_long, e_toggle;
    int            n_press [NB];
    int            n_rel   [NB];

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        logic p;
        if (!rst_n) begin
            m_s1 = '1; m_s2 = '1;
            e_level = '0; e_press = '0; e_release = '0; e_long = '0; e_toggle = '0;
            for (int i = 0; i < NB; i++) begin
                m_run[i] = 0; m_held[i] = 0;
            end
        end else begin
            e_press = '0; e_release = '0; e_long = '0;
            for (int i = 0; i < NB; i++) begin
                p = ~m_s2[i];
                if (p != e_level[i]) begin
                    m_run[i]++;
                    if (m_run[i] == DEB + 1) begin
                        m_run[i]   = 0;
                        e_level[i] = p;
                        if (p) begin
                            e_press[i]  = 1'b1;
                            e_toggle[i] = ~e_toggle[i];
                            m_held[i]   = 0;
                        end else begin
                            e_release[i] = 1'b1;
                        end
                    end
                end else begin
                    if (e_level[i] && m_run[i] == 0) begin
                        m_held[i]++;
                        if (m_held[i] == LONG) e_long[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = bif.btn_n;
        end
    endtask

    // One clock: update the model on the edge, compare 1 ns later
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("level",   8'(bif.btn_level),   8'(e_level));
        chk("press",   8'(bif.btn_press),   8'(e_press));
        chk("release", 8'(bif.btn_release), 8'(e_release));
        chk("long",    8'(bif.btn_long),    8'(e_long));
        chk("toggle",  8'(bif.btn_toggle),  8'(e_toggle));
        for (int i = 0; i < NB; i++) begin
            if (bif.btn_press[i])   n_press[i]++;
            if (bif.btn_release[i]) n_rel[i]++;
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        int p0, r0;
        for (int i = 0; i < NB; i++) begin
            n_press[i] = 0; n_rel[i] = 0;
        end
        bif.btn_n = '1;
        rst_n = 1'b0;
        ticks(3);
        chk("reset_outputs", 8'({bif.btn_level, bif.btn_toggle, bif.btn_press}), 8'h00);
        rst_n = 1'b1;
        ticks(2);

        // 1: clean press on channel 0 lands after the 7th edge
        bif.btn_n[0] = 1'b0;
        ticks(6);
        chk("t1_press_early", 8'(bif.btn_press[0]), 8'd0);
        tick();
        chk("t1_press",  8'(bif.btn_press),  8'b001);
        chk("t1_level",  8'(bif.btn_level),  8'b001);
        chk("t1_toggle", 8'(bif.btn_toggle), 8'b001);
        tick();
        chk("t1_press_once", 8'(bif.btn_press[0]), 8'd0);

        // 3: long press LONG edges after the press edge, never repeated
        ticks(LONG - 2);
        chk("t3_long_early", 8'(bif.btn_long[0]), 8'd0);
        tick();
        chk("t3_long", 8'(bif.btn_long[0]), 8'd1);
        p0 = 0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (bif.btn_long[0]) p0++;
        end
        chk("t3_no_second_long", 8'(p0), 8'd0);

        // 2: short bounces on channel 1 are rejected
        for (int r = 0; r < 5; r++) begin
            bif.btn_n[1] = 1'b0; ticks(3);
            bif.btn_n[1] = 1'b1; ticks(3);
        end
        ticks(4);
        chk("t2_no_press", 8'(n_press[1]), 8'd0);
        chk("t2_level_toggle", 8'({bif.btn_level[1], bif.btn_toggle[1]}), 8'd0);

        // 4: release glitch ignored, then stable release
        p0 = n_press[0]; r0 = n_rel[0];
        bif.btn_n[0] = 1'b1; ticks(2);
        bif.btn_n[0] = 1'b0; ticks(8);
        chk("t4_glitch_level", 8'(bif.btn_level[0]), 8'd1);
        chk("t4_glitch_events", 8'((n_press[0] - p0) + (n_rel[0] - r0)), 8'd0);
        bif.btn_n[0] = 1'b1;
        ticks(6);
        chk("t4_release_early", 8'(bif.btn_release[0]), 8'd0);
        tick();
        chk("t4_release", 8'(bif.btn_release[0]), 8'd1);
        chk("t4_level",   8'(bif.btn_level[0]),   8'd0);
        chk("t4_toggle_kept", 8'(bif.btn_toggle[0]), 8'd1);

        // 5: two full cycles on channel 2
        p0 = n_press[2]; r0 = n_rel[2];
        bif.btn_n[2] = 1'b0; ticks(10);
        chk("t5_toggle_1", 8'(bif.btn_toggle[2]), 8'd1);
        bif.btn_n[2] = 1'b1; ticks(10);
        bif.btn_n[2] = 1'b0; ticks(10);
        chk("t5_toggle_2", 8'(bif.btn_toggle[2]), 8'd0);
        bif.btn_n[2] = 1'b1; ticks(10);
        chk("t5_press_count",   8'(n_press[2] - p0), 8'd2);
        chk("t5_release_count", 8'(n_rel[2] - r0),   8'd2);

        // 6: reset mid-debounce with the button held, then fresh press
        bif.btn_n[1] = 1'b0;
        ticks(4);
        rst_n = 1'b0;
        tick();
        chk("t6_reset_outputs",
            8'({bif.btn_level, bif.btn_press, bif.btn_toggle}), 8'h00);
        rst_n = 1'b1;
        ticks(6);
        chk("t6_press_early", 8'(bif.btn_press[1]), 8'd0);
        tick();
        chk("t6_press", 8'(bif.btn_press[1]), 8'd1);
        bif.btn_n[1] = 1'b1;
        ticks(10);

        // Random bouncing on all channels with rare resets
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NB; i++) begin
                if ($urandom_range(0, 99) < 12) bif.btn_n[i] = ~bif.btn_n[i];
            end
            rst_n = ($urandom_range(0, 599) != 0);
            tick();
        end
        rst_n = 1'b1;
        bif.btn_n = '1;
        ticks(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Front-end conditioning stage for the board push-buttons (active-low pins, logic 0 while held). It synchronises each raw pin, debounces it with a per-button state machine, and produces clean event outputs: debounced level, one-cycle press/release/long-press pulses, and a press-toggled flag. Its outputs drive the LED countdown/control logic directly, which therefore no longer does its own edge detection on raw pins.

Parameters:
NUM_BTN, 3, number of independent button channels (bit i = USER_PBi)
DEB_CYCLES, 1000000, cycles a new level must stay stable before acceptance (20 ms at 50 MHz); minimum 2
LONG_CYCLES, 100000000, cycles held in PRESSED before a long-press event (2 s at 50 MHz); minimum 2
CNT_W, 32, width of the debounce and hold counters; must hold LONG_CYCLES-1 and DEB_CYCLES-1

Ports:
clk  input  1  system clock, 50 MHz, all logic on rising edge
rst_n  input  1  reset, synchronous, active-low
btn_n  input  NUM_BTN  raw asynchronous button pins, 0 = pressed
btn_level  output  NUM_BTN  debounced state, 1 = pressed
btn_press  output  NUM_BTN  one-cycle pulse on accepted press
btn_release  output  NUM_BTN  one-cycle pulse on accepted release
btn_long  output  NUM_BTN  one-cycle pulse, at most once per press, after LONG_CYCLES held
btn_toggle  output  NUM_BTN  flips on every btn_press pulse

Behaviour:
- Reset (rst_n=0 sampled on an edge): sync flops <= 1 (released); FSM <= IDLE; all counters <= 0; long_done <= 0; every output <= 0, including btn_toggle.
- Synchroniser: two flops per channel, btn_n -> s1 -> s2. The FSM uses only s2, inverted internally so that p = ~s2 = 1 when pressed.
- Channels are fully independent: own FSM, debounce counter, hold counter and long_done bit. All outputs are registered.
- FSM per channel:
  - IDLE (level=0): if p=1, go to DEB_PRESS with deb_cnt<=0.
  - DEB_PRESS (level=0):
    - if p=0, return to IDLE with no pulse (bounce rejected);
    - else if deb_cnt==DEB_CYCLES-1, go to PRESSED; btn_press=1 for one cycle; level<=1; toggle flips; hold_cnt<=0; long_done<=0;
    - else deb_cnt++.
  - PRESSED (level=1):
    - if p=0, go to DEB_RELEASE with deb_cnt<=0;
    - else if hold_cnt==LONG_CYCLES-1 and long_done=0, btn_long=1 for one cycle and long_done<=1;
    - else, if hold_cnt<LONG_CYCLES-1, hold_cnt++ (saturates; never wraps).
  - DEB_RELEASE (level=1):
    - if p=1, return to PRESSED with no press pulse; hold_cnt and long_done are kept;
    - else if deb_cnt==DEB_CYCLES-1, go to IDLE; btn_release=1 for one cycle; level<=0;
    - else deb_cnt++. hold_cnt is frozen in this state.
- Latency: number edges from edge 0, the first edge at which btn_n=0 is sampled into s1, with the pin stable from then on.
  - s2=0 after edge 1; IDLE->DEB_PRESS on edge 2.
  - btn_press and btn_level go high after edge DEB_CYCLES+2. Release has the same latency.
  - btn_long goes high LONG_CYCLES edges after the edge that set btn_press, provided there are no release glitches.
- btn_press, btn_release and btn_long are never high in the same cycle on the same channel. btn_release and btn_long cannot coincide.
- Button held through reset: after rst_n returns to 1 it is treated as a fresh press. It is debounced normally and emits btn_press.
- Reset asserted mid-debounce or mid-hold: no pulses are emitted in the reset cycle; outputs are 0 after that edge.
- btn_toggle is updated only by accepted presses. Bounces, long presses and releases never change it.

Test Plan:
(Sim parameters: DEB_CYCLES=4, LONG_CYCLES=10, NUM_BTN=3.)
1. Reset, then btn_n[0] 1->0 held (edge 0) -> btn_press[0] high for exactly the cycle after edge 6; btn_level[0]=1 from then; btn_toggle[0]=1; channels 1 and 2 stay 0.
2. btn_n[1] low for 3 cycles then high, repeated 5 times -> no btn_press[1], btn_level[1] and btn_toggle[1] stay 0.
3. Channel 0 pressed (1), then held 10 more cycles -> btn_long[0] single pulse 10 edges after the btn_press edge; held 20 more cycles -> no second pulse.
4. While PRESSED, btn_n[0] goes high for 2 cycles then low -> no btn_release, no new btn_press, btn_level stays 1. Then a stable release -> btn_release[0] pulse after 2+4+1 edges and btn_level[0]=0.
5. Two full press/release cycles on channel 2 -> btn_toggle[2] goes 0->1->0; exactly 2 btn_press and 2 btn_release pulses.
6. rst_n=0 for 1 cycle while in DEB_PRESS with btn_n held low -> all outputs 0 after that edge; after release of reset, btn_press asserts 7 edges later (2 sync + 4 debounce + 1).
